// File: rtl/ssd_multiplex_scanner.sv
// Seven-segment scan driver for NUM_DIGITS common-anode digits.
// A slot counter selects each digit for SLOT_CYCLES clocks. The first
// DEAD_CYCLES of every slot keep all anodes off so the previous digit cannot
// ghost. The low PWM_BITS of the slot counter give the brightness PWM phase.
// All display inputs are captured into shadow registers once per frame, so
// the display never shows a mix of old and new data within one frame.
// Optional macro SSD_LEADING_ZERO_BLANK_EN turns on leading-zero suppression.
module ssd_multiplex_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 262144,
  parameter int DEAD_CYCLES = 64,
  parameter int PWM_BITS    = 4
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [4*NUM_DIGITS-1:0]                               digit_values,
  input  logic [NUM_DIGITS-1:0]                                 digit_blank,
  input  logic [NUM_DIGITS-1:0]                                 dp_mask,
  input  logic [PWM_BITS-1:0]                                   brightness,
  output logic [NUM_DIGITS-1:0]                                 anodes_n,
  output logic [6:0]                                            cathodes_n,
  output logic                                                  dp_n,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] scan_index,
  output logic                                                  frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_V    = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] vals_sh_q, vals_sh_d;
  logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [PWM_BITS-1:0]     bright_sh_q, bright_sh_d;
  logic [NUM_DIGITS-1:0]   anodes_n_q, anodes_n_d;
  logic [6:0]              cathodes_n_q, cathodes_n_d;
  logic                    dp_n_q, dp_n_d;
  logic [IDX_W-1:0]        scan_index_q, scan_index_d;
  logic                    frame_done_q, frame_done_d;

  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   lz_vec;
  logic [3:0]              cur_nib;
  logic                    cur_blank, cur_dp, cur_lz, pwm_gate, digit_on;
  logic [6:0]              seg;

  // Slot/digit sequencing and once-per-frame shadow capture.
  always_comb begin
    frame_end   = (slot_cnt_q == LAST_SLOT) && (idx_q == LAST_IDX);
    slot_cnt_d  = slot_cnt_q + 1'b1;
    idx_d       = idx_q;
    vals_sh_d   = vals_sh_q;
    blank_sh_d  = blank_sh_q;
    dp_sh_d     = dp_sh_q;
    bright_sh_d = bright_sh_q;
    if (slot_cnt_q == LAST_SLOT) begin
      slot_cnt_d = '0;
      idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    if (frame_end) begin
      vals_sh_d   = digit_values;
      blank_sh_d  = digit_blank;
      dp_sh_d     = dp_mask;
      bright_sh_d = brightness;
    end
  end

  // Leading-zero suppression mask, built from the top digit downward.
  always_comb begin
    lz_vec = '0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    begin
      logic chain;
      chain = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        chain     = chain && (vals_sh_q[4*i +: 4] == 4'h0);
        lz_vec[i] = chain;
      end
    end
`endif
  end

  // Select the current digit's shadow data and build the next output word.
  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b1;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = vals_sh_q[4*i +: 4];
        cur_blank = blank_sh_q[i];
        cur_dp    = dp_sh_q[i];
        cur_lz    = lz_vec[i];
      end
    end
    case (cur_nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    pwm_gate = (bright_sh_q == {PWM_BITS{1'b1}}) ||
               (slot_cnt_q[PWM_BITS-1:0] < bright_sh_q);
    digit_on = (slot_cnt_q >= DEAD_V) && !cur_blank && !cur_lz && pwm_gate;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anodes_n_d[i] = !(digit_on && (idx_q == IDX_W'(i)));
    end
    cathodes_n_d = digit_on ? seg : 7'h7F;
    dp_n_d       = digit_on ? !cur_dp : 1'b1;
    scan_index_d = idx_q;
    frame_done_d = frame_end;
  end

  // State, shadow and registered-output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      vals_sh_q    <= '0;
      blank_sh_q   <= '1;
      dp_sh_q      <= '0;
      bright_sh_q  <= '0;
      anodes_n_q   <= '1;
      cathodes_n_q <= 7'h7F;
      dp_n_q       <= 1'b1;
      scan_index_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      vals_sh_q    <= vals_sh_d;
      blank_sh_q   <= blank_sh_d;
      dp_sh_q      <= dp_sh_d;
      bright_sh_q  <= bright_sh_d;
      anodes_n_q   <= anodes_n_d;
      cathodes_n_q <= cathodes_n_d;
      dp_n_q       <= dp_n_d;
      scan_index_q <= scan_index_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anodes_n   = anodes_n_q;
  assign cathodes_n = cathodes_n_q;
  assign dp_n       = dp_n_q;
  assign scan_index = scan_index_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_multiplex_scanner.sv
// Bench for ssd_multiplex_scanner: directed walk through the scan sequence
// with hand-computed pin values, then random input churn against a
// frame-level model of what each digit slot must show.
module tb_ssd_multiplex_scanner;
  localparam int N     = 3;
  localparam int SLOT  = 8;
  localparam int DEAD  = 1;
  localparam int PB    = 2;
  localparam int FRAME = N * SLOT;

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] digit_values = '0;
  logic [2:0]  digit_blank = '0;
  logic [2:0]  dp_mask = '0;
  logic [1:0]  brightness = '0;
  logic [2:0]  anodes_n;
  logic [6:0]  cathodes_n;
  logic        dp_n;
  logic [1:0]  scan_index;
  logic        frame_done;

  ssd_multiplex_scanner #(
    .NUM_DIGITS(N), .SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD), .PWM_BITS(PB)
  ) dut (
    .clk(clk), .reset(reset), .digit_values(digit_values),
    .digit_blank(digit_blank), .dp_mask(dp_mask), .brightness(brightness),
    .anodes_n(anodes_n), .cathodes_n(cathodes_n), .dp_n(dp_n),
    .scan_index(scan_index), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: position in the frame picks the digit and the slot
  // cycle; a frame snapshot of the inputs decides what that digit shows.
  int          step;
  logic [11:0] m_val;
  logic [2:0]  m_blank, m_dp;
  logic [1:0]  m_br;
  logic [2:0]  e_an;
  logic [6:0]  e_ca;
  logic        e_dp, e_fd;
  logic [1:0]  e_idx;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      step = 0; m_val = '0; m_blank = '1; m_dp = '0; m_br = '0;
      e_an = '1; e_ca = 7'h7F; e_dp = 1'b1; e_idx = '0; e_fd = 1'b0;
    end else begin
      int p, d, c;
      logic on, supp;
      p = step % FRAME;
      d = p / SLOT;
      c = p % SLOT;
      supp = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      if (d > 0) begin
        supp = 1'b1;
        for (int k = d; k < N; k++) if (m_val[4*k +: 4] != 4'h0) supp = 1'b0;
      end
`endif
      on = (c >= DEAD) && !m_blank[d] && !supp &&
           ((m_br == 2'b11) || ((c % (1 << PB)) < int'(m_br)));
      e_an  = on ? ~(3'b001 << d) : 3'b111;
      e_ca  = on ? SEG[m_val[4*d +: 4]] : 7'h7F;
      e_dp  = on ? ~m_dp[d] : 1'b1;
      e_idx = 2'(d);
      e_fd  = (p == FRAME - 1);
      if (p == FRAME - 1) begin
        m_val = digit_values; m_blank = digit_blank; m_dp = dp_mask; m_br = brightness;
      end
      step++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("anodes_n", 32'(anodes_n), 32'(e_an));
      check("cathodes_n", 32'(cathodes_n), 32'(e_ca));
      check("dp_n", 32'(dp_n), 32'(e_dp));
      check("scan_index", 32'(scan_index), 32'(e_idx));
      check("frame_done", 32'(frame_done), 32'(e_fd));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_anodes", 32'(anodes_n), 32'h7);
    check("rst_cathodes", 32'(cathodes_n), 32'h7F);
    check("rst_dp", 32'(dp_n), 32'h1);
    check("rst_index", 32'(scan_index), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    chk_en = 1'b1;

    brightness = 2'd3; digit_blank = 3'b000; digit_values = 12'h3A7; dp_mask = 3'b000;
    reset = 1'b1;
    tick(23);
    check("fd_before_24", 32'(frame_done), 32'h0);
    tick(1);
    check("fd_at_24", 32'(frame_done), 32'h1);
    tick(1);
    check("f2_dead_anodes", 32'(anodes_n), 32'h7);
    tick(1);
    check("f2_d0_anodes", 32'(anodes_n), 32'b110);
    check("f2_d0_seg7", 32'(cathodes_n), 32'b0001111);
    tick(4);
    digit_values = 12'h111;
    tick(4);
    check("f2_d1_anodes", 32'(anodes_n), 32'b101);
    check("f2_d1_segA", 32'(cathodes_n), 32'b0001000);
    tick(8);
    check("f2_d2_seg3", 32'(cathodes_n), 32'b0000110);
    tick(8);
    check("f3_d0_seg1", 32'(cathodes_n), 32'b1001111);

    brightness = 2'd1; digit_blank = 3'b010; dp_mask = 3'b001;
    tick(22);
    check("fd_at_72", 32'(frame_done), 32'h1);
    tick(4);
    check("pwm1_off_c3", 32'(anodes_n), 32'h7);
    tick(1);
    check("pwm1_on_c4", 32'(anodes_n), 32'b110);
    check("dp_on_d0", 32'(dp_n), 32'h0);
    tick(8);
    check("blank_d1_anodes", 32'(anodes_n), 32'h7);
    check("blank_d1_cath", 32'(cathodes_n), 32'h7F);

    digit_blank = 3'b000; brightness = 2'd3;
    tick(22);
    check("f5_d1_lit", 32'(anodes_n), 32'b101);
    #2 reset = 1'b0;
    #1;
    check("async_rst_anodes", 32'(anodes_n), 32'h7);
    check("async_rst_cath", 32'(cathodes_n), 32'h7F);
    check("async_rst_dp", 32'(dp_n), 32'h1);
    check("async_rst_index", 32'(scan_index), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    check("post_rst_index", 32'(scan_index), 32'h0);
    tick(9);
    check("post_rst_dark", 32'(anodes_n), 32'h7);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) digit_values = 12'($urandom);
      if ($urandom_range(0, 39) == 0) digit_blank = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) dp_mask = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) brightness = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 799) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ssd_multiplex_scanner.md
Name: ssd_multiplex_scanner

Overview:
Parametrised seven-segment scan driver that time-multiplexes NUM_DIGITS common-anode digits from one clock. It is the successor to the fixed 4-digit, divider-tapped scan logic in our board tops. New over that logic:
- any digit count
- full hex decode plus per-digit blank and decimal-point masks
- anti-ghosting dead time
- PWM brightness
- frame-coherent input snapshot
It sits between game/score logic and the An*/Ca..Cg/Dp board pins.

Parameters:
NUM_DIGITS, 4, digits scanned (1..16); anode[i] drives digit i, digit 0 rightmost
SLOT_CYCLES, 262144, clk cycles each digit is selected (>= 2^PWM_BITS)
DEAD_CYCLES, 64, cycles at start of each slot with all anodes off (< SLOT_CYCLES)
PWM_BITS, 4, brightness resolution

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
digit_values  in  4*NUM_DIGITS  hex nibble per digit; digit i = [4i+3:4i]
digit_blank  in  NUM_DIGITS  1 = digit i dark
dp_mask  in  NUM_DIGITS  1 = decimal point on for digit i
brightness  in  PWM_BITS  duty control; 0 = off, all-ones = full on
anodes_n  out  NUM_DIGITS  active-low anode enables
cathodes_n  out  7  active-low {a,b,c,d,e,f,g}
dp_n  out  1  active-low decimal point
scan_index  out  clog2(NUM_DIGITS), min 1  digit currently in slot
frame_done  out  1  one-cycle pulse at end of last slot

Behaviour:
- Reset (reset==0, async):
  - slot_cnt=0, digit index=0
  - shadow values=0, shadow blank=all ones, shadow dp=0, shadow brightness=0
  - anodes_n=all ones, cathodes_n=7'h7F, dp_n=1, scan_index=0, frame_done=0
- slot_cnt counts 0..SLOT_CYCLES-1 and wraps.
- On wrap, digit index advances 0,1,...,NUM_DIGITS-1,0. Non-power-of-2 counts wrap explicitly; the index never takes values >= NUM_DIGITS.
- Snapshot: in the cycle where slot_cnt==SLOT_CYCLES-1 and index==NUM_DIGITS-1, the four shadow registers load from their inputs. frame_done=1 in that same cycle, otherwise 0.
  - Consequence: input changes become visible only from the next frame; no tearing inside a frame.
  - Because shadow blank resets to all ones, the first frame after reset is dark.
- Digit on-condition, evaluated on shadow data:
  - slot_cnt >= DEAD_CYCLES, and
  - shadow blank bit for the current index == 0, and
  - PWM gate: pwm_phase = slot_cnt[PWM_BITS-1:0]; gate = (brightness == all ones) or (pwm_phase < brightness).
- When on: anodes_n has only the current index bit low. Otherwise anodes_n is all ones.
- cathodes_n is the hex decode of the current shadow nibble (0-9, A, b, C, d, E, F; standard active-low patterns, e.g. 0=7'b0000001, 8=7'b0000000, A=7'b0001000). It is forced to 7'h7F while the digit is off.
- dp_n = ~(shadow dp bit) while on, else 1.
- All outputs are registered: one cycle behind internal slot_cnt/index state.
- Reset asserted mid-frame: outputs go to reset values immediately (async); scanning restarts at digit 0, slot_cnt 0.

Optional Feature:
SSD_LEADING_ZERO_BLANK_EN:
- Defined: digits are additionally blanked from NUM_DIGITS-1 downward while their shadow nibble is 0 and every higher digit is also 0/suppressed. Digit 0 is never suppressed. Evaluated on shadow data, so it is constant within a frame.
- Undefined: zero digits display "0" unless masked by digit_blank.

Test Plan:
(Params for all: NUM_DIGITS=3, SLOT_CYCLES=8, DEAD_CYCLES=1, PWM_BITS=2.)
1. Reset, then brightness=3, digit_blank=0, digit_values=12'h3A7.
   - Frame 1: anodes_n stays 3'b111 throughout; frame_done pulses at cycle 24.
   - Frame 2: digit0 shows "7" (cathodes 7'b0001111) on anodes_n=3'b110 for 7 cycles after 1 dead cycle, then "A", then "3".
2. Change digit_values to 12'h111 mid-frame 2.
   - Frame 2 continues showing 3A7; 111 appears from frame 3.
3. brightness=1.
   - Per slot, anode low only on cycles where pwm_phase==0 and slot_cnt>=1: slot cycles 4 only → 1 on-cycle per 8.
   - brightness=0 → anodes_n never low.
4. digit_blank=3'b010, dp_mask=3'b001.
   - Digit1 slot keeps anodes_n=3'b111, cathodes 7'h7F.
   - Digit0 slot has dp_n=0.
5. Assert reset in digit1 slot.
   - Outputs go to reset values within the same cycle (async).
   - After release, scan_index=0 and the frame is dark.
6. With SSD_LEADING_ZERO_BLANK_EN, digit_values=12'h005.
   - Digits 2 and 1 dark, digit 0 shows "5".
   - With 12'h000, only digit 0 shows "0".
